// File: rtl/kypd_seg_display.sv
// rtl/kypd_seg_display.sv - keypad press debouncer, 4-digit entry register and 7-segment scan driver (option: LEADING_ZERO_BLANK_EN)
module kypd_seg_display #(
  parameter int unsigned REFRESH_DIV     = 100000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        clear,
  output logic        entry_strobe,
  output logic [3:0]  entry_code,
  output logic [15:0] digits,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int unsigned RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [23:0]   DEB_LAST = 24'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [23:0]   cnt_q, cnt_d;
  logic          accept;

  logic [15:0]   digits_q, digits_d;
  logic          strobe_q, strobe_d;
  logic [3:0]    code_q, code_d;

  logic [RW-1:0] ref_q, ref_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    cur_nib;
  logic          blank;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Press FSM: a press or a release must be stable for DEBOUNCE_CYCLES before it counts
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_valid) begin
          state_d = ST_DEBOUNCE;
          cnt_d   = 24'd0;
        end
      end
      ST_DEBOUNCE: begin
        if (!key_valid) begin
          state_d = ST_IDLE;
        end else if (cnt_q == DEB_LAST) begin
          accept  = 1'b1;
          state_d = ST_HELD;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      ST_HELD: begin
        if (!key_valid) begin
          state_d = ST_RELEASE;
          cnt_d   = 24'd0;
        end
      end
      ST_RELEASE: begin
        if (key_valid) begin
          state_d = ST_HELD;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Entry register: shift in accepted codes; clear wins over a same-cycle shift
  always_comb begin
    digits_d = digits_q;
    strobe_d = accept;
    code_d   = code_q;
    if (accept) begin
      digits_d = {digits_q[11:0], key_code};
      code_d   = key_code;
    end
    if (clear) begin
      digits_d = 16'h0000;
    end
  end

  // Scan: step the lit digit every REFRESH_DIV cycles and register anode/cathode drive
  always_comb begin
    ref_d = (ref_q == REF_LAST) ? '0 : ref_q + RW'(1);
    sel_d = (ref_q == REF_LAST) ? sel_q + 2'd1 : sel_q;
    cur_nib = digits_q[4*sel_q +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    case (sel_q)
      2'd1:    blank = (digits_q[15:4] == 12'h000);
      2'd2:    blank = (digits_q[15:8] == 8'h00);
      2'd3:    blank = (digits_q[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
    an_d  = ~(4'b0001 << sel_q);
    seg_d = blank ? 7'b1111111 : hex_to_seg(cur_nib);
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 24'd0;
      digits_q <= 16'h0000;
      strobe_q <= 1'b0;
      code_q   <= 4'h0;
      ref_q    <= '0;
      sel_q    <= 2'd0;
      an_q     <= 4'b1111;
      seg_q    <= 7'b1111111;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      strobe_q <= strobe_d;
      code_q   <= code_d;
      ref_q    <= ref_d;
      sel_q    <= sel_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign entry_strobe = strobe_q;
  assign entry_code   = code_q;
  assign digits       = digits_q;
  assign an           = an_q;
  assign seg          = seg_q;

endmodule

// File: tb/tb_kypd_seg_display.sv
// tb/tb_kypd_seg_display.sv - randomized self-checking bench for kypd_seg_display against a run-length model
module tb_kypd_seg_display;

  localparam int R = 4;
  localparam int D = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        clear = 1'b0;
  logic        entry_strobe;
  logic [3:0]  entry_code;
  logic [15:0] digits;
  logic [3:0]  an;
  logic [6:0]  seg;

  kypd_seg_display #(.REFRESH_DIV(R), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .clear(clear), .entry_strobe(entry_strobe), .entry_code(entry_code),
    .digits(digits), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int n_checks = 0;
  int n_fail   = 0;
  int n_str    = 0;

  int          m_e;
  bit          m_armed;
  int          m_hi, m_lo;
  logic [15:0] m_digits;
  logic        m_strobe;
  logic [3:0]  m_code;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_e = 0; m_armed = 1'b1; m_hi = 0; m_lo = 0;
    m_digits = 16'h0; m_strobe = 1'b0; m_code = 4'h0;
    m_an = 4'b1111; m_seg = 7'b1111111;
  endtask

  // one clock edge of the reference: press accepted after D+1 high samples, re-armed after D+1 low samples
  task automatic model_step(input logic kv, input logic [3:0] kc, input logic clr);
    logic [15:0] prev;
    int sel;
    bit blank;
    prev = m_digits;
    m_e++;
    sel = ((m_e - 1) / R) % 4;
    m_an = ~(4'b0001 << sel);
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (sel > 0 && (prev >> (4 * sel)) == 16'h0) blank = 1'b1;
`endif
    m_seg = blank ? 7'b1111111 : hex_tab[prev[4*sel +: 4]];
    if (kv) begin m_hi++; m_lo = 0; end else begin m_lo++; m_hi = 0; end
    m_strobe = 1'b0;
    if (m_armed && m_hi == D + 1) begin
      m_armed  = 1'b0;
      m_strobe = 1'b1;
      m_code   = kc;
      m_digits = {prev[11:0], kc};
    end
    if (!m_armed && m_lo == D + 1) m_armed = 1'b1;
    if (clr) m_digits = 16'h0;
  endtask

  task automatic cyc(input logic kv, input logic [3:0] kc, input logic clr);
    key_valid = kv; key_code = kc; clear = clr;
    @(posedge clk);
    model_step(kv, kc, clr);
    #1;
    check("an", an, m_an);
    check("seg", seg, m_seg);
    check("digits", digits, m_digits);
    check("strobe", entry_strobe, m_strobe);
    if (m_strobe) check("code", entry_code, m_code);
    if (entry_strobe) n_str++;
  endtask

  task automatic do_reset(input logic kv);
    key_valid = kv; clear = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, 7'b1111111);
    check("rst_digits", digits, 16'h0);
    check("rst_strobe", entry_strobe, 1'b0);
    check("rst_code", entry_code, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press(input logic [3:0] kc);
    repeat (5) cyc(1'b1, kc, 1'b0);
    repeat (5) cyc(1'b0, 4'h0, 1'b0);
  endtask

  task automatic goto_digit0();
    for (int k = 0; k < 4 * R + 1 && m_an != 4'b1110; k++) cyc(1'b0, 4'h0, 1'b0);
    check("an_d0", an, 4'b1110);
  endtask

  initial begin
    int s0;
    logic kv;
    int run;

    @(negedge clk);
    do_reset(1'b0);
    cyc(1'b0, 4'h0, 1'b0);
    check("an_first", an, 4'b1110);
    repeat (20) cyc(1'b0, 4'h0, 1'b0);

    s0 = n_str;
    repeat (10) cyc(1'b1, 4'h5, 1'b0);
    check("one_strobe", n_str - s0, 1);
    check("digits_5", digits, 16'h0005);
    repeat (6) cyc(1'b0, 4'h0, 1'b0);
    goto_digit0();
    check("seg_5", seg, 7'b0010010);

    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hA);
    check("digits_234a", digits, 16'h234A);
    goto_digit0();
    check("seg_a", seg, 7'b0001000);

    s0 = n_str;
    repeat (2) cyc(1'b1, 4'h6, 1'b0);
    repeat (6) cyc(1'b0, 4'h0, 1'b0);
    check("glitch_nostrobe", n_str - s0, 0);
    check("glitch_digits", digits, 16'h234A);
    s0 = n_str;
    repeat (5) cyc(1'b1, 4'h9, 1'b0);
    cyc(1'b0, 4'h0, 1'b0);
    repeat (4) cyc(1'b1, 4'h9, 1'b0);
    repeat (6) cyc(1'b0, 4'h0, 1'b0);
    check("bounce_one_strobe", n_str - s0, 1);
    check("bounce_digits", digits, 16'h34A9);

    cyc(1'b0, 4'h0, 1'b1);
    press(4'h1); press(4'h2);
    check("digits_12", digits, 16'h0012);
    repeat (3) cyc(1'b1, 4'h7, 1'b0);
    cyc(1'b1, 4'h7, 1'b1);
    check("clr_strobe", entry_strobe, 1'b1);
    check("clr_code", entry_code, 4'h7);
    check("clr_digits", digits, 16'h0);
    repeat (5) cyc(1'b0, 4'h0, 1'b0);

    cyc(1'b0, 4'h0, 1'b1);
    press(4'h3); press(4'h0);
    check("digits_30", digits, 16'h0030);
    for (int k = 0; k < 16; k++) begin
      cyc(1'b0, 4'h0, 1'b0);
      case (an)
`ifdef LEADING_ZERO_BLANK_EN
        4'b0111: check("lzb_d3", seg, 7'b1111111);
        4'b1011: check("lzb_d2", seg, 7'b1111111);
`else
        4'b0111: check("lz_d3", seg, 7'b1000000);
        4'b1011: check("lz_d2", seg, 7'b1000000);
`endif
        4'b1101: check("lz_d1", seg, 7'b0110000);
        4'b1110: check("lz_d0", seg, 7'b1000000);
        default: check("lz_an", an, 4'b1110);
      endcase
    end

    repeat (2) cyc(1'b1, 4'hE, 1'b0);
    @(posedge clk);
    #1;
    do_reset(1'b1);
    s0 = n_str;
    repeat (6) cyc(1'b1, 4'hE, 1'b0);
    check("rst_held_strobe", n_str - s0, 1);
    check("rst_held_digits", digits, 16'h000E);
    repeat (5) cyc(1'b0, 4'h0, 1'b0);

    kv = 1'b0;
    for (int i = 0; i < 60; i++) begin
      logic [3:0] kc;
      kv = ~kv;
      run = $urandom_range(1, 7);
      kc = 4'($urandom_range(0, 15));
      for (int j = 0; j < run; j++) cyc(kv, kc, ($urandom_range(0, 24) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/kypd_seg_display.md
Name: kypd_seg_display

Overview:
- Output end of the keypad path: consumes the 4-bit key code and key-pressed level from the keypad scanner.
- Debounces each press and shifts accepted codes into a 4-digit entry register.
- Time-multiplexes the digits onto the Nexys3 common-anode seven-segment display (an/seg, both active low).
- Sits in the PmodKYPD top alongside the keypad decoder; also gives the calculator core a one-cycle strobe per accepted key.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit stays lit (100 MHz -> 1 kHz per digit); minimum 2.
- DEBOUNCE_CYCLES, 1000000, cycles key_valid must be stable to accept a press or a release (10 ms); minimum 2.

Ports:
- clk  input  1  100 MHz onboard clock.
- rst  input  1  asynchronous, active-high reset.
- key_valid  input  1  level, high while the scanner reports a key pressed.
- key_code  input  4  hex code of the pressed key (0x0-0xF).
- clear  input  1  synchronous clear of the entry register.
- entry_strobe  output  1  one-cycle pulse when a digit is accepted.
- entry_code  output  4  code accepted, valid with entry_strobe.
- digits  output  16  entry register {d3,d2,d1,d0}; d0 is the newest, rightmost digit.
- an  output  4  digit anodes, active low; an[0] is the rightmost digit.
- seg  output  7  cathodes {g,f,e,d,c,b,a}, active low.

Behaviour:
- Reset (async, immediate):
  - Press FSM to IDLE; debounce and refresh counters to 0; sel=0.
  - digits=0; entry_strobe=0; entry_code=0.
  - an=4'b1111; seg=7'b1111111.
- Press FSM (states IDLE, DEBOUNCE, HELD, RELEASE), 24-bit counter cnt:
  - IDLE: key_valid=1 -> DEBOUNCE with cnt=0.
  - DEBOUNCE: key_valid=0 -> IDLE. Otherwise cnt++; at cnt==DEBOUNCE_CYCLES-1:
    - sample key_code;
    - shift digits left ({d2,d1,d0,key_code}, old d3 discarded);
    - assert entry_strobe and entry_code on the next cycle (registered);
    - go to HELD.
  - HELD: key_valid=0 -> RELEASE with cnt=0. A held key never repeats.
  - RELEASE: key_valid=1 -> HELD. At cnt==DEBOUNCE_CYCLES-1 -> IDLE.
  - A glitch shorter than DEBOUNCE_CYCLES is never accepted.
- clear:
  - Sets digits=0 the cycle after it is sampled.
  - Beats a shift in the same cycle: digits=0, but entry_strobe still fires.
  - Does not change FSM state.
- Scan:
  - refresh counter counts 0..REFRESH_DIV-1 and wraps; on wrap, sel increments mod 4 (3->0).
  - an and seg are registered from sel and the selected digit: 1-cycle latency.
  - an = ~(4'b0001 << sel); seg = hex pattern of digits[4*sel+3:4*sel].
  - First cycle after reset release: an=4'b1110.
- Hex patterns (active low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- A digit change is visible from the next refresh update of that digit; no tearing within a digit period.
- Mid-press reset returns to IDLE with nothing shifted. A key still held after reset is accepted after the full debounce.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: digits above the most significant nonzero digit show seg=7'b1111111 while their anode still scans. d0 is never blanked, so all-zero shows a single "0".
- Undefined: all four digits always display, including leading zeros.

Test Plan (REFRESH_DIV=4, DEBOUNCE_CYCLES=3):
- Reset, release -> an=1111 and seg=1111111 during reset. Then an steps 1110,1101,1011,0111 every 4 cycles, wrapping, with seg=1000000 throughout (leading-zero feature off).
- key_valid=1, key_code=5 held 10 cycles -> exactly one entry_strobe with entry_code=5; digits=16'h0005; seg=0010010 while an=1110.
- Press codes 1,2,3,4,A with clean releases -> digits=16'h234A (the 1 shifted out); rightmost digit seg=0001000.
- key_valid high for 2 cycles only -> no strobe, digits unchanged. Release bounce of 1 cycle low inside HELD -> no second strobe.
- clear asserted in the same cycle as acceptance of 7 with digits=16'h0012 -> digits=0, entry_strobe=1, entry_code=7.
- With LEADING_ZERO_BLANK_EN and digits=16'h0030 -> an=0111 and 1011 show 1111111; 1101 shows 0110000; 1110 shows 1000000.
